// File: rtl/dm_store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_store_buffer_if
// Description : Request/response bundle between the cpu and the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_store_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SB_DEPTH   = 4
);
    logic                      dm_read;
    logic                      dm_write;
    logic [31:0]               read_address_to_dm;
    logic [31:0]               write_address_to_dm;
    logic [DATA_WIDTH-1:0]     data_to_dm;
    logic [DATA_WIDTH-1:0]     data_from_dm;
    logic                      dm_ready;
    logic                      misaligned;
    logic [$clog2(SB_DEPTH):0] sb_count;

    modport master (
        output dm_read, dm_write, read_address_to_dm, write_address_to_dm, data_to_dm,
        input  data_from_dm, dm_ready, misaligned, sb_count
    );

    modport slave (
        input  dm_read, dm_write, read_address_to_dm, write_address_to_dm, data_to_dm,
        output data_from_dm, dm_ready, misaligned, sb_count
    );
endinterface
`default_nettype wire

// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dm_store_buffer
// Description : Single-port word RAM behind an in-order store buffer with
//               read forwarding; buffered writes drain in read-free cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int SB_DEPTH   = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    dm_store_buffer_if.slave   bus
);
    localparam int c_ptr_w = $clog2(SB_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(SB_DEPTH);

    logic [DATA_WIDTH-1:0] r_ram     [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] r_sb_idx  [SB_DEPTH];
    logic [DATA_WIDTH-1:0] r_sb_data [SB_DEPTH];
    logic [c_ptr_w-1:0]    r_head;
    logic [c_ptr_w-1:0]    r_tail;
    logic [c_cnt_w-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_misaligned;

    logic                  w_ready;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_drain;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_fwd_data;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_bad_align;
    logic                  w_unused;

    assign w_ready  = (r_count != c_full);
    assign w_rd_acc = bus.dm_read  && w_ready;
    assign w_wr_acc = bus.dm_write && w_ready;
    // The single RAM port goes to an accepted read first; drain takes idle cycles.
    assign w_drain  = (r_count != '0) && !w_rd_acc;

    assign w_rd_idx = bus.read_address_to_dm[ADDR_WIDTH+1:2];
    assign w_wr_idx = bus.write_address_to_dm[ADDR_WIDTH+1:2];
    assign w_unused = ^{bus.read_address_to_dm[31:ADDR_WIDTH+2],
                        bus.write_address_to_dm[31:ADDR_WIDTH+2]};

    assign w_bad_align = (w_rd_acc && (bus.read_address_to_dm[1:0]  != 2'b00)) ||
                         (w_wr_acc && (bus.write_address_to_dm[1:0] != 2'b00));

    // Walk from head to tail so that a later match overrides: last hit is youngest.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if ((c_cnt_w'(k) < r_count) &&
                (r_sb_idx[r_head + c_ptr_w'(k)] == w_rd_idx)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_sb_data[r_head + c_ptr_w'(k)];
            end
        end
    end

    assign w_rd_data = w_fwd_hit ? w_fwd_data : r_ram[w_rd_idx];

    // RAM contents survive reset; only the drain path writes it.
    always_ff @(posedge clk) begin
        if (!reset && w_drain) begin
            r_ram[r_sb_idx[r_head]] <= r_sb_data[r_head];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) begin
            r_sb_idx[r_tail]  <= w_wr_idx;
            r_sb_data[r_tail] <= bus.data_to_dm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_tail <= r_tail + c_ptr_w'(1);
            end
            if (w_drain) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            case ({w_wr_acc, w_drain})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_rd_acc) begin
                r_rdata <= w_rd_data;
            end
            if (w_bad_align) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    assign bus.data_from_dm = r_rdata;
    assign bus.dm_ready     = w_ready;
    assign bus.misaligned   = r_misaligned;
    assign bus.sb_count     = r_count;

endmodule
`default_nettype wire
